wb_timer: RTL and testbench
===========================

// Module: wb_timer
// PURPOSE
// Wishbone slave timer peripheral; responder at the Timer window (0x0002_0300-0x0002_03FF) of
// the SoC interconnect. Prescaled 32-bit up-counter with compare match, optional auto-reload,
// sticky match flag and level interrupt. Register accesses complete with a registered one-cycle ack.
// PARAMETERS
// DATA_WIDTH      32  bus data width and counter/compare width
// PRESCALE_WIDTH  16  width of prescaler reload and prescaler counter
// PORTS
// clk         in   1   system clock
// rst         in   1   reset, synchronous, active-high
// wb_addr     in   8   byte offset within window; [1:0] ignored
// wb_dat_i    in   32  write data
// wb_dat_o    out  32  read data, valid while wb_ack=1
// wb_we       in   1   1=write, 0=read
// wb_sel      in   4   byte lane enables for writes
// wb_stb      in   1   strobe, already qualified with cyc by interconnect
// wb_ack      out  1   transfer acknowledge
// irq         out  1   interrupt, level: STATUS.MATCH & CTRL.IRQ_EN
// BEHAVIOUR
// Reset: wb_ack=0, wb_dat_o=0, irq=0; all registers, prescaler counter, MATCH = 0.
// Handshake: ack <= stb & ~ack; single-cycle pulse, one cycle after stb seen. Held stb => ack every
//   2nd cycle. Write and read data capture occur on the cycle stb&~ack is sampled. No err output.
// Register map (offset): 0x00 CTRL  [0]EN [1]AUTO_RELOAD [2]IRQ_EN, other bits read 0
//   0x04 PRESCALE [PRESCALE_WIDTH-1:0]; 0x08 COUNT (RW); 0x0C COMPARE (RW)
//   0x10 STATUS [0]MATCH, sticky, write-1-to-clear; other offsets: read 0, writes ignored, acked.
// Writes honour wb_sel per byte lane; bits beyond a field's width ignored.
// Prescaler: when EN=1, pcnt increments each clk; when pcnt==PRESCALE, tick=1 and pcnt<=0.
//   PRESCALE=0 => tick every clk. EN=0 freezes pcnt and COUNT (values held, not cleared).
//   Any write to PRESCALE clears pcnt to 0 in the same update.
// Counter on tick: if COUNT==COMPARE: MATCH<=1; COUNT<=AUTO_RELOAD ? 0 : COUNT+1.
//   Else COUNT<=COUNT+1; wrap 0xFFFF_FFFF->0 silently (no flag).
// Priority / simultaneous events:
//   - bus write to COUNT same cycle as tick: write value wins, tick increment discarded; a compare
//     match evaluated on the pre-write COUNT in that cycle still sets MATCH.
//   - W1C of MATCH same cycle as new match: set wins, MATCH stays 1.
//   - write to COMPARE takes effect for comparisons from next cycle.
//   - write CTRL.EN 1->0 same cycle as tick: tick suppressed.
// Reads return register value as of the capture cycle (pre-write state if none pending).
// irq combinational from registered MATCH and IRQ_EN; clearing IRQ_EN drops irq without clearing MATCH.
// Reset mid-transaction: ack forced 0 next cycle, transaction dropped; master must retry.
// TESTING
// T1 reset: assert rst 2 cycles during stb -> wb_ack=0, irq=0, all regs read 0 after release.
// T2 bus: write COMPARE=0xDEAD_BEEF sel=4'b0011 -> read 0x0000_BEEF; ack exactly 1 cycle after stb,
//   held stb gives ack on alternate cycles; read 0x40 -> 0, acked.
// T3 prescale: PRESCALE=3, COUNT=0, CTRL=0x1 -> COUNT increments every 4 clk; after 40 clk COUNT=10.
// T4 match/reload: PRESCALE=0, COMPARE=5, CTRL=0x7 -> MATCH and irq rise after 6th tick, COUNT=0
//   next; repeat period 6 ticks; STATUS write 0x1 clears, irq falls next cycle.
// T5 free-run wrap: COUNT=0xFFFF_FFFE, COMPARE=0x10, CTRL=0x1 -> 0xFFFF_FFFF, 0x0, 0x1; no MATCH.
// T6 collisions: W1C of MATCH on match cycle -> MATCH stays 1; COUNT write 0x100 on tick cycle ->
//   COUNT=0x100; EN cleared mid-run -> COUNT frozen for 20 clk.

Source files
------------

// File: rtl/wb_timer.sv
// wb_timer: Wishbone timer peripheral with a prescaled up-counter, compare match, auto-reload and a level irq.
// Ports: clk/rst (sync, active-high); wb_addr byte offset, wb_dat_i/wb_sel write data and lanes,
//   wb_we/wb_stb request, wb_dat_o/wb_ack registered response, irq = STATUS.MATCH & CTRL.IRQ_EN.
module wb_timer #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              wb_addr,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic                    wb_stb,
  output logic                    wb_ack,
  output logic                    irq
);
  logic                      r_ack, r_match;
  logic [DATA_WIDTH-1:0]     r_dat, r_count, r_compare;
  logic [2:0]                r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale, r_pcnt;
  logic                      w_acc, w_wr, w_run, w_tick, w_hit, w_clr;
  logic                      w_wr_ctrl, w_wr_pre, w_wr_cnt, w_wr_cmp, w_wr_stat;
  logic [5:0]                w_idx;
  logic [2:0]                w_ctrl_nx;
  logic [DATA_WIDTH-1:0]     w_mask, w_rd;
  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_mask
    assign w_mask[8*b +: 8] = {8{wb_sel[b]}};
  end
  assign w_acc     = wb_stb & ~r_ack;
  assign w_wr      = w_acc & wb_we;
  assign w_idx     = wb_addr[7:2];
  assign w_wr_ctrl = w_wr & (w_idx == 6'd0);
  assign w_wr_pre  = w_wr & (w_idx == 6'd1);
  assign w_wr_cnt  = w_wr & (w_idx == 6'd2);
  assign w_wr_cmp  = w_wr & (w_idx == 6'd3);
  assign w_wr_stat = w_wr & (w_idx == 6'd4);
  assign w_ctrl_nx = w_wr_ctrl ? (r_ctrl & ~w_mask[2:0]) | (wb_dat_i[2:0] & w_mask[2:0]) : r_ctrl;
  // A write that clears EN suppresses the tick that would otherwise land in the same cycle.
  assign w_run     = r_ctrl[0] & w_ctrl_nx[0];
  assign w_tick    = w_run & (r_pcnt == r_prescale);
  // Match is judged on the pre-write COUNT, so it survives a colliding COUNT write.
  assign w_hit     = w_tick & (r_count == r_compare);
  assign w_clr     = w_wr_stat & wb_sel[0] & wb_dat_i[0];
  assign w_rd      = (w_idx == 6'd0) ? DATA_WIDTH'(r_ctrl) :
                     (w_idx == 6'd1) ? DATA_WIDTH'(r_prescale) :
                     (w_idx == 6'd2) ? r_count :
                     (w_idx == 6'd3) ? r_compare :
                     (w_idx == 6'd4) ? DATA_WIDTH'(r_match) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_match    <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= (w_acc & ~wb_we) ? w_rd : '0;
      r_ctrl  <= w_ctrl_nx;
      if (w_wr_pre)
        r_prescale <= (r_prescale & ~w_mask[PRESCALE_WIDTH-1:0]) | (wb_dat_i[PRESCALE_WIDTH-1:0] & w_mask[PRESCALE_WIDTH-1:0]);
      r_pcnt  <= (w_wr_pre | w_tick) ? '0 : w_run ? r_pcnt + 1'b1 : r_pcnt;
      r_count <= w_wr_cnt ? (r_count & ~w_mask) | (wb_dat_i & w_mask) :
                 w_tick ? ((w_hit & r_ctrl[1]) ? '0 : r_count + 1'b1) : r_count;
      if (w_wr_cmp)
        r_compare <= (r_compare & ~w_mask) | (wb_dat_i & w_mask);
      // Setting a new match outranks a simultaneous write-1-to-clear.
      r_match <= w_hit | (r_match & ~w_clr);
    end
  end
  assign wb_ack   = r_ack;
  assign wb_dat_o = r_dat;
  assign irq      = r_match & r_ctrl[2];
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: self-checking bench for wb_timer with directed vectors, corner sequences and a random reference-model run.
module tb_wb_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic        wb_stb = 1'b0;
  logic        wb_ack, irq;
  int n_checks = 0;
  int n_errors = 0;
  logic        m_ack = 0, m_match = 0;
  logic [31:0] m_dat = 0, m_cnt = 0, m_cmp = 0, m_ctrl = 0, m_pre = 0, m_pcnt = 0;
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[19];
  wb_timer #(.DATA_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  // One clock: the reference model advances from the currently driven inputs, then every output is compared.
  task automatic step();
    logic        acc, wr, tick, hit, n_ack, n_match;
    logic [5:0]  idx;
    logic [31:0] rv, n_dat, n_ctrl, n_pre, n_pcnt, n_cnt, n_cmp;
    acc = wb_stb && !m_ack;
    wr = acc && wb_we;
    idx = wb_addr[7:2];
    case (idx)
      6'd0: rv = m_ctrl;
      6'd1: rv = m_pre;
      6'd2: rv = m_cnt;
      6'd3: rv = m_cmp;
      6'd4: rv = {31'd0, m_match};
      default: rv = 0;
    endcase
    n_ctrl = (wr && idx == 0) ? merge(m_ctrl, wb_dat_i, wb_sel) & 32'h7 : m_ctrl;
    tick = m_ctrl[0] && n_ctrl[0] && (m_pcnt == m_pre);
    hit = tick && (m_cnt == m_cmp);
    n_pre = (wr && idx == 1) ? merge(m_pre, wb_dat_i, wb_sel) & 32'hFFFF : m_pre;
    if (wr && idx == 1) n_pcnt = 0;
    else if (m_ctrl[0] && n_ctrl[0]) n_pcnt = tick ? 0 : m_pcnt + 1;
    else n_pcnt = m_pcnt;
    if (wr && idx == 2) n_cnt = merge(m_cnt, wb_dat_i, wb_sel);
    else if (hit && m_ctrl[1]) n_cnt = 0;
    else if (tick) n_cnt = m_cnt + 1;
    else n_cnt = m_cnt;
    n_cmp = (wr && idx == 3) ? merge(m_cmp, wb_dat_i, wb_sel) : m_cmp;
    n_match = hit || (m_match && !(wr && idx == 4 && wb_sel[0] && wb_dat_i[0]));
    n_ack = acc;
    n_dat = (acc && !wb_we) ? rv : 0;
    if (rst) begin
      n_ack = 0; n_dat = 0; n_ctrl = 0; n_pre = 0; n_pcnt = 0; n_cnt = 0; n_cmp = 0; n_match = 0;
    end
    @(posedge clk);
    #1;
    m_ack = n_ack; m_dat = n_dat; m_ctrl = n_ctrl; m_pre = n_pre;
    m_pcnt = n_pcnt; m_cnt = n_cnt; m_cmp = n_cmp; m_match = n_match;
    chk("model_ack", wb_ack, m_ack);
    chk("model_rdata", wb_dat_o, m_dat);
    chk("model_irq", irq, m_match & m_ctrl[2]);
  endtask
  task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    wb_stb = 1; wb_we = we; wb_addr = a; wb_dat_i = d; wb_sel = s;
    step();
    chk("bus_ack", wb_ack, 1);
    rd = wb_dat_o;
    wb_stb = 0; wb_we = 0;
    step();
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] x;
    bus(1, a, d, 4'hF, x);
  endtask
  task automatic rd_exp(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] x;
    bus(0, a, 0, 4'hF, x);
    chk(name, x, exp);
  endtask
  initial begin
    logic [31:0] x;
    tbl[0]  = '{0, 8'h00, 0, 4'hF, 32'h0};
    tbl[1]  = '{0, 8'h04, 0, 4'hF, 32'h0};
    tbl[2]  = '{0, 8'h08, 0, 4'hF, 32'h0};
    tbl[3]  = '{0, 8'h0C, 0, 4'hF, 32'h0};
    tbl[4]  = '{0, 8'h10, 0, 4'hF, 32'h0};
    tbl[5]  = '{1, 8'h0C, 32'hDEAD_BEEF, 4'b0011, 32'h0};
    tbl[6]  = '{0, 8'h0C, 0, 4'hF, 32'h0000_BEEF};
    tbl[7]  = '{0, 8'h40, 0, 4'hF, 32'h0};
    tbl[8]  = '{1, 8'h04, 32'hFFFF_1234, 4'hF, 32'h0};
    tbl[9]  = '{0, 8'h04, 0, 4'hF, 32'h0000_1234};
    tbl[10] = '{1, 8'h08, 32'h1122_3344, 4'b1010, 32'h0};
    tbl[11] = '{0, 8'h0A, 0, 4'hF, 32'h1100_3300};
    tbl[12] = '{1, 8'h00, 32'hFFFF_FFFE, 4'b0001, 32'h0};
    tbl[13] = '{0, 8'h00, 0, 4'hF, 32'h0000_0006};
    tbl[14] = '{1, 8'h00, 32'h0, 4'hF, 32'h0};
    tbl[15] = '{1, 8'h40, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[16] = '{0, 8'h14, 0, 4'hF, 32'h0};
    tbl[17] = '{1, 8'h10, 32'h1, 4'hF, 32'h0};
    tbl[18] = '{0, 8'h10, 0, 4'hF, 32'h0};
    // Reset asserted while a write is being strobed.
    wb_stb = 1; wb_we = 1; wb_addr = 8'h0C; wb_dat_i = 32'h1234_5678; wb_sel = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ack", wb_ack, 0);
      chk("rst_irq", irq, 0);
    end
    rst = 0; wb_stb = 0; wb_we = 0;
    step();
    for (int i = 0; i < 19; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].sel, x);
      if (!tbl[i].we) chk($sformatf("vec%0d", i), x, tbl[i].exp);
    end
    // Held strobe acks on alternate cycles.
    wb_stb = 1; wb_we = 0; wb_addr = 8'h0C;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("held_ack%0d", i), wb_ack, (i % 2 == 0) ? 1 : 0);
    end
    wb_stb = 0;
    step();
    // Prescale 3: one count per 4 clocks.
    wr(8'h04, 3); wr(8'h08, 0); wr(8'h00, 1);
    repeat (39) step();
    rd_exp("prescale_count", 8'h08, 10);
    wr(8'h00, 0);
    // Compare match with auto-reload and irq.
    wr(8'h04, 0); wr(8'h08, 0); wr(8'h0C, 5); wr(8'h10, 1); wr(8'h00, 7);
    for (int i = 2; i <= 6; i++) begin
      step();
      chk($sformatf("match_irq%0d", i), irq, (i == 6) ? 1 : 0);
    end
    rd_exp("reload_count", 8'h08, 0);
    wr(8'h10, 1);
    chk("w1c_irq", irq, 0);
    step();
    chk("period_irq_lo", irq, 0);
    step();
    chk("period_irq_hi", irq, 1);
    wr(8'h00, 0);
    chk("irqen_off_irq", irq, 0);
    rd_exp("irqen_off_match", 8'h10, 1);
    wr(8'h10, 1);
    rd_exp("cleared_match", 8'h10, 0);
    // Free-running wrap through zero, no match.
    wr(8'h04, 1); wr(8'h08, 32'hFFFF_FFFE); wr(8'h0C, 32'h10); wr(8'h00, 1);
    rd_exp("wrap0", 8'h08, 32'hFFFF_FFFE);
    rd_exp("wrap1", 8'h08, 32'hFFFF_FFFF);
    rd_exp("wrap2", 8'h08, 32'h0);
    rd_exp("wrap3", 8'h08, 32'h1);
    rd_exp("wrap_nomatch", 8'h10, 0);
    wr(8'h00, 0);
    // W1C colliding with a new match keeps MATCH set.
    wr(8'h04, 0); wr(8'h08, 0); wr(8'h0C, 3); wr(8'h10, 1); wr(8'h00, 1);
    step(); step();
    wr(8'h10, 1);
    rd_exp("w1c_collide", 8'h10, 1);
    wr(8'h00, 0); wr(8'h10, 1);
    // COUNT write on a tick cycle wins; EN cleared on a tick cycle freezes COUNT.
    wr(8'h04, 1); wr(8'h08, 0); wr(8'h00, 1);
    wr(8'h08, 32'h100);
    rd_exp("count_write_tick", 8'h08, 32'h100);
    wr(8'h00, 0);
    repeat (20) step();
    rd_exp("en_freeze", 8'h08, 32'h101);
    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      int k;
      k = $urandom_range(0, 9);
      rst = ($urandom_range(0, 199) == 0);
      wb_stb = $urandom_range(0, 1);
      wb_we = $urandom_range(0, 1);
      wb_addr = (k < 6) ? 8'(k * 4) : 8'($urandom);
      wb_dat_i = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
      wb_sel = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      step();
    end
    rst = 0; wb_stb = 0; wb_we = 0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
